// File: rtl/instr_fetch.sv
// instr_fetch: program counter, instruction-memory request/response tracking and
// an in-order buffer of fetched instructions feeding decode.
// Optional build macro FETCH_MISALIGN_EN: a misaligned redirect traps into HALT
// and raises MisalignErr. Without it, redirect targets are forced word-aligned.
//
// Handshakes (valid/ready semantics):
//   imem   : a request transfers on ImemReq & ImemGnt. ImemAddr stays stable while
//            ImemReq=1 and ImemGnt=0. Responses (ImemRvalid) come back in request
//            order, at least one cycle after their grant.
//   decode : an instruction transfers on InstrValid & DecodeReady. Instr/PCF/PCPlus4
//            stay stable while InstrValid=1 and DecodeReady=0, unless PCSrc flushes.
module instr_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        DecodeReady,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
`ifdef FETCH_MISALIGN_EN
  output logic        MisalignErr,
`endif
  output logic [1:0]  dbg_state_o
);

  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
`ifdef FETCH_MISALIGN_EN
    , ST_HALT = 2'd2
`endif
  } state_e;

  state_e        state_q;
  logic [31:0]   pc_q;
  logic [CW-1:0] out_q;      // granted requests whose response has not arrived
  logic [CW-1:0] drop_q;     // responses still to be discarded after a redirect
  logic [CW-1:0] cnt_q;      // buffered instructions
  logic [PW-1:0] aq_wr_q, aq_rd_q;
  logic [PW-1:0] fifo_wr_q, fifo_rd_q;

  // Address queue holds the PC of every in-flight request; it never exceeds
  // MAX_OUTSTANDING <= FIFO_DEPTH entries, so FIFO_DEPTH slots suffice.
  logic [31:0] aq_mem     [FIFO_DEPTH];
  logic [31:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0] fifo_instr [FIFO_DEPTH];

  logic [31:0]   target;
  logic          grant, resp, push, pop;
  logic [CW-1:0] out_d;
  logic [CW:0]   credit_used;

`ifdef FETCH_MISALIGN_EN
  logic misalign;
  assign target   = PCTarget;
  assign misalign = (PCTarget[1:0] != 2'b00);
`else
  logic [1:0] unused_target_lsbs;
  assign unused_target_lsbs = PCTarget[1:0];
  assign target             = {PCTarget[31:2], 2'b00};
`endif

  // A slot is reserved in the buffer for every request at issue time, so a
  // response can always be pushed without a full check.
  assign credit_used = {1'b0, out_q} + {1'b0, cnt_q};
  assign ImemReq     = (state_q == ST_RUN) &&
                       (credit_used < (CW+1)'(FIFO_DEPTH)) &&
                       (out_q < CW'(MAX_OUTSTANDING)) &&
                       !PCSrc;
  assign ImemAddr    = pc_q;

  assign grant = ImemReq & ImemGnt;
  // A response with nothing outstanding (e.g. a request lost to reset) is ignored.
  assign resp  = ImemRvalid && (out_q != '0);
  // Stale words (drop>0), words arriving in HALT or during a redirect are discarded.
  assign push  = resp && (drop_q == '0) && (state_q == ST_RUN) && !PCSrc;
  assign pop   = InstrValid & DecodeReady;
  assign out_d = out_q + CW'(grant) - CW'(resp);

  assign InstrValid  = (cnt_q != '0);
  assign Instr       = InstrValid ? fifo_instr[fifo_rd_q] : NOP;
  assign PCF         = InstrValid ? fifo_pc[fifo_rd_q] : 32'h0000_0000;
  assign PCPlus4     = PCF + 32'd4;
  assign dbg_state_o = state_q;
`ifdef FETCH_MISALIGN_EN
  assign MisalignErr = (state_q == ST_HALT);
`endif

  // Control state: FSM, PC, request accounting and buffer pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      aq_wr_q   <= '0;
      aq_rd_q   <= '0;
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
    end else begin
      out_q <= out_d;
      if (grant) aq_wr_q <= aq_wr_q + PW'(1);
      if (resp)  aq_rd_q <= aq_rd_q + PW'(1);
      if (PCSrc) begin
        // Everything still in flight after this edge belongs to the old path.
        pc_q      <= target;
        drop_q    <= out_d;
        cnt_q     <= '0;
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
`ifdef FETCH_MISALIGN_EN
        state_q   <= misalign ? ST_HALT : ST_RUN;
`else
        state_q   <= ST_RUN;
`endif
      end else begin
        if (grant) pc_q <= pc_q + 32'd4;
        if (resp && (drop_q != '0)) drop_q <= drop_q - CW'(1);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
        if (push) fifo_wr_q <= fifo_wr_q + PW'(1);
        if (pop)  fifo_rd_q <= fifo_rd_q + PW'(1);
        if (state_q == ST_IDLE) state_q <= ST_RUN;
      end
    end
  end

  // Storage arrays: request PCs and fetched {pc, instr} entries.
  always_ff @(posedge clk) begin
    if (grant) aq_mem[aq_wr_q] <= pc_q;
    if (push) begin
      fifo_pc[fifo_wr_q]    <= aq_mem[aq_rd_q];
      fifo_instr[fifo_wr_q] <= ImemRdata;
    end
  end

endmodule
